mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Multi-cycle RV32M multiply/divide unit, parametrised in operand width. It sits
//  beside the single-cycle ALU in EX and covers MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//  Multiplication is radix-2 shift-add; division is radix-2 restoring. Both take one
//  bit per cycle. The pipeline stalls on busy and captures result on the done pulse.
// PARAMETERS
//  XLEN  32  operand/result width in bits (>=4, even)
// PORTS
//  clk     in   1     clock, rising edge
//  rst     in   1     synchronous active-high reset
//  start   in   1     request; sampled only in IDLE
//  flush   in   1     abort the in-flight op (branch/exception kill)
//  op      in   3     funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  a       in   XLEN  rs1 operand (dividend / multiplicand)
//  b       in   XLEN  rs2 operand (divisor / multiplier)
//  busy    out  1     high from the accept edge until the edge that raises done
//  done    out  1     one-cycle pulse; result valid in the same cycle
//  result  out  XLEN  final value; held from done until the next accept
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, result=0, all internal registers 0.
//  - FSM states: IDLE -> CALC -> FIX -> IDLE.
//    IDLE & start: latch op and |a|,|b| (signedness from op), plus the result sign.
//      Counter = XLEN. Next state is CALC and busy=1.
//    CALC: one iteration per cycle, counter decrements. Counter reaching 1 -> FIX.
//    FIX: apply two's-complement sign correction and select the hi/lo/quotient/remainder.
//      Register result, pulse done, clear busy, return to IDLE.
//  - Latency: done is asserted exactly XLEN+2 cycles after the accept edge
//    (34 cycles for XLEN=32).
//  - Multiply: 2*XLEN product register. MUL returns the low XLEN bits; MULH/MULHSU/MULHU
//    return the high XLEN bits. Signed x signed, signed x unsigned and unsigned x unsigned
//    are chosen per op.
//  - Divide: quotient sign = sign(a)^sign(b); remainder sign = sign(a) (RISC-V truncation).
//  - Fast paths bypass CALC/FIX: IDLE -> done on the next edge (latency 1), busy=1 for
//    that one cycle.
//    divide by zero (b==0):       DIV/DIVU -> all ones; REM/REMU -> a
//    signed overflow (DIV/REM, a=100..0, b=all ones): DIV -> a; REM -> 0
//  - start while busy or in the done cycle's own edge is ignored. There is no queueing,
//    and the requester holds start until it sees busy.
//  - flush in any non-IDLE state -> IDLE on the next edge. done stays 0, result is
//    unchanged, busy drops. flush in IDLE has no effect; flush and start in the same
//    IDLE cycle -> no accept.
//  - rst mid-operation overrides everything, including flush: reset values on the next edge.
//  - done and start in the same cycle: start is sampled in IDLE on the following cycle.
//    Back-to-back ops therefore have a 1-cycle gap.
//  - Counter width is $clog2(XLEN)+1. All arithmetic is unsigned on magnitudes, and sign
//    is applied only in FIX.
// TESTING
//  1 MUL a=7,b=-3 -> done 34 cycles after accept, result=0xFFFFFFEB
//  2 MULH a=0x80000000,b=0x80000000 -> 0x40000000; MULHU same operands -> 0x40000000;
//    MULHSU a=-1,b=2 -> 0xFFFFFFFF
//  3 DIV a=-7,b=2 -> 0xFFFFFFFD; REM a=-7,b=2 -> 0xFFFFFFFF; DIVU a=100,b=7 -> 14;
//    REMU a=100,b=7 -> 2
//  4 DIV a=5,b=0 -> 0xFFFFFFFF and REM -> 5, done 1 cycle after accept;
//    DIV a=0x80000000,b=-1 -> 0x80000000; REM -> 0
//  5 start DIVU, flush at cycle 10 -> busy=0 next cycle, no done pulse, result keeps
//    its prior value; start during busy ignored
//  6 rst asserted at cycle 5 of a MUL -> busy=0, done=0, result=0 next edge;
//    a new op then completes normally with XLEN=8: MUL 12*11 -> 0x84 after 10 cycles

Source files
------------

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
//   Multi-cycle RV32M multiply/divide unit, used beside the single-cycle ALU in
//   EX. Handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//   The multiplier is radix-2 shift-add and the divider is radix-2 restoring.
//   Each retires one bit per cycle, working on operand magnitudes. The sign is
//   applied once the iterations are finished.
//
// Ports
//   clk     in   1     rising-edge clock
//   rst     in   1     synchronous active-high reset
//   start   in   1     request, sampled only in IDLE outside the done cycle
//   flush   in   1     kills the in-flight operation
//   op      in   3     funct3 (000 MUL .. 111 REMU)
//   a       in   XLEN  rs1: dividend / multiplicand
//   b       in   XLEN  rs2: divisor / multiplier
//   busy    out  1     high from the accept edge to the edge that raises done
//   done    out  1     one-cycle pulse, result valid in the same cycle
//   result  out  XLEN  final value, held until the next completion or reset
//
// Timing
//   Normal operation takes XLEN+2 edges from accept to done:
//     - XLEN CALC edges.
//     - Two FIX edges: the sign correction, then the hi/lo select.
//   Fast paths take 1 edge. These are divide by zero and signed overflow. Their
//   answer is preloaded into the product register. The FSM enters FIX directly
//   at the select step.
// -----------------------------------------------------------------------------
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   opnd_q;      // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] prod_q;      // {hi, lo}: product, or {remainder, quotient}
    logic [CW-1:0]     cnt_q;
    logic              neg_q_q;     // sign of product / quotient
    logic              neg_r_q;     // sign of remainder (follows dividend)
    logic              fix_final_q; // FIX second step: select and publish
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    // ------------------------------------------------------------------
    // Operand decode at accept
    // ------------------------------------------------------------------
    logic            a_signed, b_signed, neg_a, neg_b;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_by_zero, div_ovf, fast, accept;

    always_comb begin
        // MUL/MULH/MULHSU/DIV/REM treat rs1 as signed.
        // MUL/MULH/DIV/REM treat rs2 as signed.
        a_signed    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        b_signed    = op[2] ? ~op[0] : ~op[1];
        neg_a       = a_signed & a[XLEN-1];
        neg_b       = b_signed & b[XLEN-1];
        a_mag       = neg_a ? -a : a;
        b_mag       = neg_b ? -b : b;
        div_by_zero = op[2] & (b == '0);
        div_ovf     = op[2] & ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);
        fast        = div_by_zero | div_ovf;
        // A start that is present during the done cycle is deliberately not
        // taken. The requester keeps start asserted, so it is accepted one
        // cycle later.
        accept      = (state == IDLE) & start & ~flush & ~done_q;
    end

    // ------------------------------------------------------------------
    // One iteration step of each algorithm
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   hi, lo;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift, div_trial;
    logic              div_ge;
    logic [2*XLEN-1:0] mul_step, div_step, fixed_prod;
    logic              sel_hi;

    always_comb begin
        hi = prod_q[2*XLEN-1:XLEN];
        lo = prod_q[XLEN-1:0];

        // Shift-add: add the multiplicand into hi when the current multiplier
        // bit is set. Then shift the whole {carry, hi, lo} right by one.
        mul_sum  = {1'b0, hi} + {1'b0, (lo[0] ? opnd_q : {XLEN{1'b0}})};
        mul_step = {mul_sum, lo[XLEN-1:1]};

        // Restoring divide: shift the next dividend bit into the partial
        // remainder. Then subtract the divisor if the result stays non-negative.
        div_shift = {hi, lo[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_trial = div_shift - {1'b0, opnd_q};
        div_step  = div_ge ? {div_trial[XLEN-1:0], lo[XLEN-2:0], 1'b1}
                           : {div_shift[XLEN-1:0], lo[XLEN-2:0], 1'b0};

        // A multiply sign fix must negate the full double-width product.
        // Otherwise MULH loses the borrow out of the low half.
        // The quotient and the remainder are negated independently.
        if (!op_q[2]) begin
            fixed_prod = neg_q_q ? -prod_q : prod_q;
        end else begin
            fixed_prod = {(neg_r_q ? -hi : hi), (neg_q_q ? -lo : lo)};
        end

        // MUL and DIV/DIVU take the low half. Everything else takes the high half.
        sel_hi = op_q[2] ? op_q[1] : (op_q[1:0] != 2'b00);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven, so
        // no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = fast ? FIX : CALC;
            CALC:    if (cnt_q == CW'(1)) state_next = FIX;
            FIX:     if (fix_final_q) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush && (state != IDLE)) state_next = IDLE;
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy   = (state != IDLE);
        done   = done_q;
        result = result_q;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. Every
        // register then samples the values from before the edge, whatever order
        // the statements appear in.
        if (rst) begin
            op_q        <= '0;
            opnd_q      <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            fix_final_q <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush && (state != IDLE)) begin
                // Abort: result keeps its previous value and done stays low.
                fix_final_q <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept) begin
                            op_q        <= op;
                            cnt_q       <= CW'(XLEN);
                            fix_final_q <= fast;
                            neg_q_q     <= fast ? 1'b0 : (neg_a ^ neg_b);
                            neg_r_q     <= fast ? 1'b0 : neg_a;
                            if (fast) begin
                                // The preload is {remainder, quotient}. The
                                // select step picks the half that op asks for.
                                prod_q <= div_by_zero ? {a, {XLEN{1'b1}}}
                                                      : {{XLEN{1'b0}}, a};
                                opnd_q <= '0;
                            end else if (op[2]) begin
                                prod_q <= {{XLEN{1'b0}}, a_mag};
                                opnd_q <= b_mag;
                            end else begin
                                prod_q <= {{XLEN{1'b0}}, b_mag};
                                opnd_q <= a_mag;
                            end
                        end
                    end
                    CALC: begin
                        prod_q <= op_q[2] ? div_step : mul_step;
                        cnt_q  <= cnt_q - CW'(1);
                    end
                    FIX: begin
                        if (!fix_final_q) begin
                            prod_q      <= fixed_prod;
                            fix_final_q <= 1'b1;
                        end else begin
                            result_q    <= sel_hi ? hi : lo;
                            done_q      <= 1'b1;
                            fix_final_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
//   Directed bench for mul_div_unit. It uses two instances:
//     - XLEN=32 for the RV32M vectors.
//     - XLEN=8 for the mid-operation reset scenario.
//   Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b, result;
    logic        busy, done;

    logic        rst8, start8, flush8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, result8;
    logic        busy8, done8;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    mul_div_unit #(.XLEN(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .flush(flush8), .op(op8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .result(result8)
    );

    // Issue one op on the 32-bit unit. Return the result and the number of
    // edges from the accept edge to done. A latency of 100 means it timed out.
    task automatic run32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] res, output int lat);
        @(negedge clk);
        if (done) @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
    endtask

    task automatic run8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        output logic [7:0] res, output int lat);
        @(negedge clk);
        if (done8) @(negedge clk);
        op8 = o; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result8;
    endtask

    task automatic test_reset;
        rst = 1'b1; rst8 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; rst8 = 1'b0;
        n_total++; if (busy !== 1'b0)      $display("FAIL reset_busy: got %b want 0", busy);      else n_pass++;
        n_total++; if (done !== 1'b0)      $display("FAIL reset_done: got %b want 0", done);      else n_pass++;
        n_total++; if (result !== 32'h0)   $display("FAIL reset_result: got %h want 0", result);  else n_pass++;
        n_total++; if (busy8 !== 1'b0)     $display("FAIL reset8_busy: got %b want 0", busy8);    else n_pass++;
        n_total++; if (done8 !== 1'b0)     $display("FAIL reset8_done: got %b want 0", done8);    else n_pass++;
        n_total++; if (result8 !== 8'h0)   $display("FAIL reset8_result: got %h want 0", result8); else n_pass++;
    endtask

    task automatic test_mul;
        logic [31:0] r;
        int          lat;
        run32(OP_MUL, 32'd7, 32'hFFFF_FFFD, r, lat);
        n_total++; if (r !== 32'hFFFF_FFEB) $display("FAIL mul_7x-3: got %h want ffffffeb", r); else n_pass++;
        n_total++; if (lat !== 34)          $display("FAIL mul_latency: got %0d want 34", lat); else n_pass++;
    endtask

    task automatic test_mul_high;
        logic [2:0]  ops  [3] = '{OP_MULH, OP_MULHU, OP_MULHSU};
        logic [31:0] va   [3] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] vb   [3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0002};
        logic [31:0] want [3] = '{32'h4000_0000, 32'h4000_0000, 32'hFFFF_FFFF};
        logic [31:0] r;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run32(ops[i], va[i], vb[i], r, lat);
            n_total++;
            if (r !== want[i]) $display("FAIL mulhigh_%0d: got %h want %h", i, r, want[i]);
            else n_pass++;
        end
        n_total++; if (lat !== 34) $display("FAIL mulhsu_latency: got %0d want 34", lat); else n_pass++;
    endtask

    task automatic test_div;
        logic [2:0]  ops  [4] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
        logic [31:0] va   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] vb   [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] want [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        logic [31:0] r;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run32(ops[i], va[i], vb[i], r, lat);
            n_total++;
            if (r !== want[i]) $display("FAIL div_%0d: got %h want %h", i, r, want[i]);
            else n_pass++;
        end
        n_total++; if (lat !== 34) $display("FAIL div_latency: got %0d want 34", lat); else n_pass++;
    endtask

    task automatic test_fast_path;
        logic [2:0]  ops  [6] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM};
        logic [31:0] va   [6] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] vb   [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] want [6] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [31:0] r;
        int          lat;
        for (int i = 0; i < 6; i++) begin
            run32(ops[i], va[i], vb[i], r, lat);
            n_total++;
            if (r !== want[i]) $display("FAIL fast_%0d: got %h want %h", i, r, want[i]);
            else n_pass++;
            n_total++;
            if (lat !== 1) $display("FAIL fast_latency_%0d: got %0d want 1", i, lat);
            else n_pass++;
        end
    endtask

    task automatic test_busy_start;
        int lat;
        int extra_done;
        @(negedge clk);
        if (done) @(negedge clk);
        op = OP_DIVU; a = 32'd1000; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        repeat (5) begin @(posedge clk); lat++; end
        #1;
        op = OP_MUL; a = 32'd2; b = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        lat++;
        start = 1'b0;
        n_total++; if (busy !== 1'b1) $display("FAIL busy_during_op: got %b want 1", busy); else n_pass++;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_total++; if (lat !== 34)       $display("FAIL busy_start_latency: got %0d want 34", lat); else n_pass++;
        n_total++; if (result !== 32'd111) $display("FAIL busy_start_result: got %h want 6f", result); else n_pass++;
        extra_done = 0;
        repeat (40) begin @(posedge clk); #1; if (done) extra_done++; end
        n_total++; if (extra_done !== 0) $display("FAIL busy_start_queued: got %0d dones want 0", extra_done); else n_pass++;
    endtask

    task automatic test_flush;
        int seen;
        @(negedge clk);
        op = OP_REMU; a = 32'd50; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        n_total++; if (busy !== 1'b0)      $display("FAIL flush_busy: got %b want 0", busy);       else n_pass++;
        n_total++; if (done !== 1'b0)      $display("FAIL flush_done: got %b want 0", done);       else n_pass++;
        n_total++; if (result !== 32'd111) $display("FAIL flush_result: got %h want 6f", result);  else n_pass++;
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (done) seen++; end
        n_total++; if (seen !== 0)         $display("FAIL flush_late_done: got %0d want 0", seen); else n_pass++;
        n_total++; if (result !== 32'd111) $display("FAIL flush_result_held: got %h want 6f", result); else n_pass++;
        // A start together with a flush in IDLE must not be accepted.
        @(negedge clk);
        op = OP_MUL; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL flush_start_idle: got busy %b want 0", busy); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        op = OP_MUL; a = 32'd3; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        n_total++; if (result !== 32'd15) $display("FAIL b2b_first: got %h want f", result); else n_pass++;
        // start stays high through the done cycle with the next operands.
        a = 32'd4; b = 32'd6;
        @(posedge clk); #1;
        n_total++; if (busy !== 1'b0) $display("FAIL b2b_done_cycle_start: got busy %b want 0", busy); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (busy !== 1'b1) $display("FAIL b2b_gap_accept: got busy %b want 1", busy); else n_pass++;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        n_total++; if (result !== 32'd24) $display("FAIL b2b_second: got %h want 18", result); else n_pass++;
        n_total++; if (lat !== 34)        $display("FAIL b2b_latency: got %0d want 34", lat);  else n_pass++;
    endtask

    task automatic test_reset_mid_op;
        logic [7:0] r;
        int         lat;
        run8(OP_MUL, 8'd3, 8'd5, r, lat);
        n_total++; if (r !== 8'h0F) $display("FAIL x8_pre_mul: got %h want 0f", r); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        op8 = OP_MUL; a8 = 8'd12; b8 = 8'd11; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst8 = 1'b1; flush8 = 1'b1;
        @(posedge clk); #1;
        rst8 = 1'b0; flush8 = 1'b0;
        n_total++; if (busy8 !== 1'b0)   $display("FAIL x8_rst_busy: got %b want 0", busy8);     else n_pass++;
        n_total++; if (done8 !== 1'b0)   $display("FAIL x8_rst_done: got %b want 0", done8);     else n_pass++;
        n_total++; if (result8 !== 8'h0) $display("FAIL x8_rst_result: got %h want 0", result8); else n_pass++;
        run8(OP_MUL, 8'd12, 8'd11, r, lat);
        n_total++; if (r !== 8'h84) $display("FAIL x8_mul: got %h want 84", r);            else n_pass++;
        n_total++; if (lat !== 10)  $display("FAIL x8_latency: got %0d want 10", lat);      else n_pass++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        rst8 = 1'b1; start8 = 1'b0; flush8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
        test_reset();
        test_mul();
        test_mul_high();
        test_div();
        test_fast_path();
        test_busy_start();
        test_flush();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
